// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: sequences the shared multi-cycle divider for DIV/MOD with zero shortcut, result cache, abort and timeout
module div_issue_ctrl #(
  parameter int TIMEOUT  = 64,
  parameter bit CACHE_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [12:0] aluSignals,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        flush,
  input  logic        div_done,
  input  logic [31:0] div_quo,
  input  logic [31:0] div_rem,
  output logic        div_start,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  output logic        stall,
  output logic [31:0] div_result,
  output logic        result_valid,
  output logic        div_timeout,
  output logic [31:0] stall_cycles
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE, ABORT} state_t;
  state_t      r_state, w_next;
  logic        r_op_div, r_cv, r_timeout;
  logic [31:0] r_div_a, r_div_b, r_tcnt, r_stall_cycles;
  logic [31:0] r_ca, r_cb, r_cq, r_cr;
  logic        w_req, w_is_div, w_zero, w_hit, w_cache_wr;
  assign w_req      = op_valid & ~flush & (aluSignals[4] | aluSignals[5]) & ~reset;
  assign w_is_div   = aluSignals[4];
  assign w_zero     = B == 32'd0;
  assign w_hit      = CACHE_EN && r_cv && A == r_ca && B == r_cb;
  // a squashed operation still returns its result, which remains worth caching
  assign w_cache_wr = div_done & (r_state == BUSY | r_state == ABORT);
  assign div_a        = r_div_a;
  assign div_b        = r_div_b;
  assign div_timeout  = r_timeout;
  assign stall_cycles = r_stall_cycles;
  always_comb begin
    w_next       = r_state;
    div_start    = 1'b0;
    stall        = 1'b0;
    result_valid = 1'b0;
    div_result   = '0;
    case (r_state)
      IDLE: if (w_req) begin
        if (w_zero || w_hit) begin
          result_valid = 1'b1;
          div_result   = w_zero ? (w_is_div ? '1 : A) : (w_is_div ? r_cq : r_cr);
        end else begin
          div_start = 1'b1;
          stall     = 1'b1;
          w_next    = BUSY;
        end
      end
      BUSY: begin
        stall  = 1'b1;
        w_next = div_done ? (flush ? IDLE : DONE) : (flush ? ABORT : BUSY);
      end
      DONE: begin
        result_valid = 1'b1;
        div_result   = r_op_div ? r_cq : r_cr;
        w_next       = IDLE;
      end
      ABORT: begin
        stall  = w_req;
        w_next = div_done ? IDLE : ABORT;
      end
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= IDLE;
      r_div_a        <= '0;
      r_div_b        <= '0;
      r_op_div       <= 1'b0;
      r_cv           <= 1'b0;
      r_timeout      <= 1'b0;
      r_tcnt         <= '0;
      r_stall_cycles <= '0;
    end else begin
      r_state <= w_next;
      if (div_start) begin
        r_div_a  <= A;
        r_div_b  <= B;
        r_op_div <= w_is_div;
        r_tcnt   <= 32'd1;
      end else if (r_state == BUSY && r_tcnt != 32'(TIMEOUT)) begin
        r_tcnt <= r_tcnt + 32'd1;
      end
      if (r_state == BUSY && r_tcnt >= 32'(TIMEOUT - 1)) r_timeout <= 1'b1;
      if (w_cache_wr) r_cv <= 1'b1;
      if (stall && r_stall_cycles != '1) r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (w_cache_wr) begin
      r_ca <= r_div_a;
      r_cb <= r_div_b;
      r_cq <= div_quo;
      r_cr <= div_rem;
    end
  end
endmodule

// File: tb/tb_div_issue_ctrl.sv
// tb_div_issue_ctrl: random and directed DIV/MOD traffic against a transaction-level model with a latency-configurable core model
module tb_div_issue_ctrl;
  logic        clk = 1'b0, reset = 1'b1, op_valid = 1'b0, flush = 1'b0, div_done = 1'b0;
  logic [12:0] aluSignals = '0;
  logic [31:0] A = '0, B = '0, div_quo = '0, div_rem = '0;
  logic        div_start, stall, result_valid, div_timeout;
  logic [31:0] div_a, div_b, div_result, stall_cycles;

  localparam logic [12:0] DIV = 13'h010, MOD = 13'h020, BOTH = 13'h030, ADD = 13'h001, XOR = 13'h100;

  div_issue_ctrl #(.TIMEOUT(64), .CACHE_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .aluSignals(aluSignals), .A(A), .B(B),
    .flush(flush), .div_done(div_done), .div_quo(div_quo), .div_rem(div_rem),
    .div_start(div_start), .div_a(div_a), .div_b(div_b), .stall(stall),
    .div_result(div_result), .result_valid(result_valid), .div_timeout(div_timeout),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0, exp_stalls = 0, core_cnt = 0, lat = 5;
  bit hang = 0, cap = 0, force_done = 0, aborting = 0, cv = 0, s_done = 0;
  logic [31:0] core_q = '0, core_r = '0, ab_a, ab_b, ca, cb;
  logic [31:0] s_start, s_stall, s_rv, s_res, s_to, s_a, s_b;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [31:0] ref_res(input bit isdiv, input logic [31:0] a, input logic [31:0] b);
    return b == 0 ? (isdiv ? 32'hFFFF_FFFF : a) : (isdiv ? a / b : a % b);
  endfunction

  task automatic cache_put(input logic [31:0] a, input logic [31:0] b);
    cv = 1; ca = a; cb = b;
  endtask

  // one clock: drive inputs after the edge, sample at the falling edge, advance the core model
  task automatic cycle(input logic ov, input logic [12:0] alu, input logic [31:0] a, input logic [31:0] b, input logic fl);
    op_valid = ov; aluSignals = alu; A = a; B = b; flush = fl;
    s_done = 0;
    if (core_cnt > 0 && !hang) begin
      core_cnt--;
      s_done = core_cnt == 0;
    end
    div_done = s_done | force_done;
    div_quo = core_q; div_rem = core_r;
    @(negedge clk);
    s_start = 32'(div_start); s_stall = 32'(stall); s_rv = 32'(result_valid);
    s_res = div_result; s_to = 32'(div_timeout); s_a = div_a; s_b = div_b;
    chk("stall_cycles", stall_cycles, 32'(exp_stalls));
    if (cap) begin
      cap = 0;
      core_q = div_b != 0 ? div_a / div_b : '1;
      core_r = div_b != 0 ? div_a % div_b : div_a;
    end
    if (div_start) begin core_cnt = lat; cap = 1; end
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic ov, input logic [12:0] alu, input logic [31:0] a, input logic [31:0] b, input int flush_at);
    bit dv, isdiv, hit;
    logic [31:0] exp_r;
    int g;
    dv = ov && (alu[4] || alu[5]);
    isdiv = alu[4];
    g = 0;
    while (aborting && dv && g < 100) begin
      cycle(ov, alu, a, b, 1'b0);
      chk("abort_stall", s_stall, 1); chk("abort_rv", s_rv, 0);
      exp_stalls++; g++;
      if (s_done) begin cache_put(ab_a, ab_b); aborting = 0; end
    end
    if (!dv) begin
      cycle(ov, alu, a, b, 1'b0);
      chk("pass_stall", s_stall, 0); chk("pass_rv", s_rv, 0); chk("pass_start", s_start, 0);
      if (s_done && aborting) begin cache_put(ab_a, ab_b); aborting = 0; end
      return;
    end
    chk("abort_drained", 32'(aborting), 0);
    exp_r = ref_res(isdiv, a, b);
    hit = cv && a == ca && b == cb;
    cycle(ov, alu, a, b, 1'b0);
    if (b == 0 || hit) begin
      chk(b == 0 ? "zero_res" : "hit_res", s_res, exp_r);
      chk("short_rv", s_rv, 1); chk("short_stall", s_stall, 0); chk("short_start", s_start, 0);
      return;
    end
    chk("start", s_start, 1); chk("start_stall", s_stall, 1); chk("start_rv", s_rv, 0);
    exp_stalls++;
    for (int n = 1; n <= 100; n++) begin
      cycle(ov, alu, a, b, n == flush_at);
      if (n == 1) begin chk("div_a", s_a, a); chk("div_b", s_b, b); end
      chk("busy_stall", s_stall, 1); chk("busy_rv", s_rv, 0); chk("busy_start", s_start, 0);
      exp_stalls++;
      if (s_done) begin
        cache_put(a, b);
        if (n == flush_at) return;
        cycle(ov, alu, a, b, 1'b0);
        chk("done_rv", s_rv, 1); chk("done_res", s_res, exp_r); chk("done_stall", s_stall, 0);
        return;
      end
      if (n == flush_at) begin aborting = 1; ab_a = a; ab_b = b; return; end
    end
    chk("busy_bound", 32'(s_done), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [12:0] alu;
    logic [31:0] a, b, pa, pb;
    int r, fa;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("rst_stall", 32'(stall), 0); chk("rst_start", 32'(div_start), 0);
    chk("rst_rv", 32'(result_valid), 0); chk("rst_to", 32'(div_timeout), 0);
    chk("rst_res", div_result, 0); chk("rst_a", div_a, 0); chk("rst_b", div_b, 0);
    chk("rst_sc", stall_cycles, 0);
    @(posedge clk); #1;
    issue(1, DIV, 100, 7, 0);
    chk("tp1_stall_cycles", stall_cycles, 6);
    issue(1, MOD, 100, 7, 0);
    issue(1, DIV, 55, 0, 0);
    issue(1, MOD, 55, 0, 0);
    issue(1, DIV, 1000, 10, 2);
    issue(1, ADD, 3, 4, 0);
    issue(1, DIV, 1000, 10, 0);
    issue(1, DIV, 9, 3, 1);
    issue(1, ADD, 1, 1, 0);
    issue(1, DIV, 8, 2, 0);
    issue(1, DIV, 77, 5, 5);
    issue(1, MOD, 77, 5, 0);
    issue(1, BOTH, 50, 7, 0);
    // timeout: core never answers
    hang = 1;
    cycle(1, DIV, 5000, 3, 1'b0);
    chk("to_start", s_start, 1);
    exp_stalls++;
    for (int n = 1; n <= 66; n++) begin
      cycle(1, DIV, 5000, 3, 1'b0);
      chk("timeout", s_to, 32'(n >= 64));
      exp_stalls++;
    end
    reset = 1;
    cycle(0, '0, 0, 0, 1'b0);
    reset = 0; exp_stalls = 0; hang = 0; core_cnt = 0; cap = 0; cv = 0; aborting = 0;
    cycle(0, '0, 0, 0, 1'b0);
    chk("rst2_stall", s_stall, 0); chk("rst2_to", s_to, 0); chk("rst2_rv", s_rv, 0);
    chk("rst2_res", s_res, 0); chk("rst2_a", s_a, 0); chk("rst2_b", s_b, 0);
    force_done = 1;
    cycle(0, '0, 0, 0, 1'b0);
    force_done = 0;
    chk("stray_rv", s_rv, 0); chk("stray_stall", s_stall, 0);
    cycle(0, '0, 0, 0, 1'b0);
    chk("stray_rv2", s_rv, 0);
    issue(1, DIV, 5000, 3, 0);
    // random traffic
    pa = 100; pb = 7;
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 5);
      alu = r < 2 ? DIV : r == 2 ? MOD : r == 3 ? BOTH : r == 4 ? ADD : XOR;
      if ($urandom_range(0, 9) < 3) begin
        a = pa; b = pb;
      end else begin
        a = $urandom_range(0, 3) == 0 ? $urandom : $urandom_range(0, 200);
        r = $urandom_range(0, 3);
        b = r == 0 ? 0 : r == 1 ? $urandom : $urandom_range(1, 20);
      end
      lat = $urandom_range(2, 8);
      fa = $urandom_range(0, 3) == 0 ? $urandom_range(1, lat) : 0;
      issue($urandom_range(0, 9) != 0, alu, a, b, fa);
      pa = a; pb = b;
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/div_issue_ctrl.md
Name: div_issue_ctrl

Overview:
- Execute-stage controller that sequences the shared multi-cycle divider core for DIV/MOD instructions.
- Detects divide ops from the ALU control word and issues a start pulse with latched operands.
- Holds the pipeline stall until the core reports done, then presents the quotient or remainder.
- Adds a divide-by-zero shortcut, a last-result reuse cache, flush/abort handling, timeout detection and a stall-cycle counter.

Parameters:
- TIMEOUT, 64: maximum BUSY cycles before `div_timeout` is raised.
- CACHE_EN, 1: 1 enables last-operand result reuse; 0 means a cache hit never occurs.

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `op_valid`  in  1  EX stage holds a valid instruction
- `aluSignals`  in  13  one-hot ALU control word; bit 4 = DIV, bit 5 = MOD
- `A`  in  32  dividend (post-forwarding)
- `B`  in  32  divisor (post-immediate-mux)
- `flush`  in  1  EX instruction is squashed this cycle
- `div_done`  in  1  core result ready; single-cycle pulse
- `div_quo`  in  32  core quotient
- `div_rem`  in  32  core remainder
- `div_start`  out  1  single-cycle start pulse to the core
- `div_a`  out  32  registered dividend to the core
- `div_b`  out  32  registered divisor to the core
- `stall`  out  1  freeze IF/ID/EX (combinational)
- `div_result`  out  32  quotient if bit 4, remainder if bit 5
- `result_valid`  out  1  `div_result` is valid this cycle
- `div_timeout`  out  1  sticky error flag
- `stall_cycles`  out  32  saturating count of cycles with `stall`=1

Behaviour:
- Clock and reset: one clock (`clk`); reset is synchronous and active-high (`reset`).
- Reset values:
  - state = IDLE
  - `div_start`, `stall`, `result_valid`, `div_timeout` = 0
  - `div_a`, `div_b`, `div_result`, `stall_cycles` = 0
  - cache invalid
  - Reset mid-operation drops everything; a later `div_done` from the old operation is ignored while in IDLE.
- Request definition: `req` = `op_valid` & !`flush` & (`aluSignals[4]` | `aluSignals[5]`). Non-divide ops never stall and never touch state.
- IDLE, when `req`, evaluated in priority order:
  1. B==0: no start; `div_result` = 32'hFFFF_FFFF for DIV or A for MOD; `result_valid`=1, `stall`=0, same cycle. Cache is not updated.
  2. Cache hit (CACHE_EN, cache valid, A==cached A, B==cached B): cached quo/rem returned same cycle; `result_valid`=1, `stall`=0.
  3. Otherwise:
     - `div_start`=1 for one cycle; `div_a`/`div_b` latched; op type latched.
     - `stall`=1 in this cycle; go to BUSY.
     - `div_a`/`div_b` are registered on this edge and valid from the BUSY cycle onward, held stable until the next start. The core samples operands in the cycle after the start pulse.
- BUSY:
  - `stall`=1; timeout counter increments.
  - On `div_done`: write quo/rem and the operands to the cache, mark it valid, go to DONE.
  - On `flush` (without `div_done`): go to ABORT.
  - Same cycle `flush` and `div_done`: the cache is written and the state goes to IDLE (result discarded).
  - Counter reaching TIMEOUT: `div_timeout`=1 (sticky until reset); state stays BUSY.
- DONE:
  - `stall`=0, `result_valid`=1, `div_result` = captured value selected by the latched op type.
  - Pipeline advances at the end of this cycle; next state IDLE.
  - Total latency from first `req` cycle = core latency + 2.
- ABORT:
  - Waits for `div_done`, which is written to the cache; then goes to IDLE.
  - `stall`=1 only if `req` is asserted, since the core is still occupied. Non-divide ops pass.
  - A `req` present when `div_done` arrives is handled on the next IDLE cycle.
- `div_result` and `result_valid` are combinational in the IDLE-shortcut cases and registered-source in DONE. `result_valid`=0 in all other cycles.
- `stall_cycles` increments each cycle `stall`=1 and saturates at 32'hFFFF_FFFF.
- Edge cases:
  - DIV and MOD both set: treated as DIV.
  - Unsigned operands throughout.

Test Plan:
1. Reset, then DIV A=100, B=7 with a core model of latency 5 → `div_start` pulse with `div_a`=100, `div_b`=7; `stall` high 6 cycles; DONE cycle gives `div_result`=14, `result_valid`=1; `stall_cycles`=6.
2. Immediately repeat MOD A=100, B=7 → cache hit: no `div_start`, `div_result`=2 in the same cycle, `stall`=0.
3. DIV A=55, B=0 → `div_result`=32'hFFFF_FFFF with no start; MOD A=55, B=0 → `div_result`=55; `stall` never asserted.
4. Start DIV 1000/10, assert `flush` on BUSY cycle 2 → ABORT. Present an ADD (no stall), then DIV 9/3 → stalls until the old `div_done`, then a new start. Afterwards DIV 1000/10 hits the cache with 100.
5. Core model never returns `div_done`, TIMEOUT=64 → `div_timeout` rises on BUSY cycle 64 and stays high; assert `reset` → all outputs 0, state IDLE; a later stray `div_done` is ignored.
6. `flush` and `div_done` in the same BUSY cycle → next state IDLE, no `result_valid` pulse, cache updated (a repeat of the same op hits).
